// File: rtl/avalon_pio_pkg.sv
// Register map and bus widths shared by the PIO top level, its bus interface and the bench.
package avalon_pio_pkg;

  localparam int AW = 3;
  localparam int DW = 32;

  localparam logic [AW-1:0] ADDR_DATA   = 3'd0;
  localparam logic [AW-1:0] ADDR_DIR    = 3'd1;
  localparam logic [AW-1:0] ADDR_MASK   = 3'd2;
  localparam logic [AW-1:0] ADDR_EDGE   = 3'd3;
  localparam logic [AW-1:0] ADDR_RISE   = 3'd4;
  localparam logic [AW-1:0] ADDR_FALL   = 3'd5;
  localparam logic [AW-1:0] ADDR_OUTSET = 3'd6;
  localparam logic [AW-1:0] ADDR_OUTCLR = 3'd7;

endpackage

// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM slave bus of the PIO: word address, read/write strobes, fixed read latency 1.
interface avalon_pio_irq_if;
  import avalon_pio_pkg::*;

  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [DW-1:0] avs_writedata;
  logic [DW-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/pio_debounce.sv
// Pad input conditioning: 2-flop synchroniser, prescaled sampling and two-sample agreement debounce.
module pio_debounce #(
  parameter int WIDTH        = 32,
  parameter int DEBOUNCE_DIV = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] stable,
  output logic             stable_upd
);

  localparam int CW     = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int DIV_M1 = (DEBOUNCE_DIV > 0) ? DEBOUNCE_DIV - 1 : 0;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] agree;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic             primed;

  assign tick  = (DEBOUNCE_DIV == 0) || (cnt == CW'(DIV_M1));
  assign agree = ~(sync2 ^ sample);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      cnt        <= '0;
      sample     <= '0;
      stable     <= '0;
      primed     <= 1'b0;
      stable_upd <= 1'b0;
    end else begin
      sync1 <= pio_in;
      sync2 <= sync1;
      cnt   <= tick ? '0 : cnt + 1'b1;
      // The priming tick loads stable outright and raises no update strobe,
      // so inputs already high at reset never look like edges.
      if (tick) begin
        sample <= sync2;
        if (!primed || DEBOUNCE_DIV == 0) stable <= sync2;
        else                               stable <= (sync2 & agree) | (stable & ~agree);
        primed <= 1'b1;
      end
      stable_upd <= tick & primed;
    end
  end

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO: output/direction registers with atomic set/clear, debounced inputs,
// per-bit rising/falling edge capture and a registered, maskable level interrupt.
module avalon_pio_irq
  import avalon_pio_pkg::*;
#(
  parameter int            WIDTH        = 32,
  parameter int            DEBOUNCE_DIV = 50000,
  parameter logic [DW-1:0] RESET_OUT    = '0,
  parameter logic [DW-1:0] RESET_DIR    = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  avalon_pio_irq_if.slave  avs,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe
);

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] new_edge;
  logic [WIDTH-1:0] edge_clr;
  logic             stable_upd;
  logic [DW-1:0]    rd_mux;

  pio_debounce #(
    .WIDTH       (WIDTH),
    .DEBOUNCE_DIV(DEBOUNCE_DIV)
  ) u_debounce (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .pio_in       (pio_in),
    .stable       (stable),
    .stable_upd   (stable_upd)
  );

  assign wd       = avs.avs_writedata[WIDTH-1:0];
  assign pio_oe   = dir;
  assign new_edge = stable_upd ? ((stable & ~stable_q & rise_en) | (~stable & stable_q & fall_en))
                               : '0;
  assign edge_clr = (avs.avs_write && avs.avs_address == ADDR_EDGE) ? wd : '0;

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      ADDR_DATA:   rd_mux[WIDTH-1:0] = stable;
      ADDR_DIR:    rd_mux[WIDTH-1:0] = dir;
      ADDR_MASK:   rd_mux[WIDTH-1:0] = mask;
      ADDR_EDGE:   rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_RISE:   rd_mux[WIDTH-1:0] = rise_en;
      ADDR_FALL:   rd_mux[WIDTH-1:0] = fall_en;
      ADDR_OUTSET: rd_mux[WIDTH-1:0] = pio_out;
      ADDR_OUTCLR: rd_mux[WIDTH-1:0] = pio_out;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pio_out          <= RESET_OUT[WIDTH-1:0];
      dir              <= RESET_DIR[WIDTH-1:0];
      mask             <= '0;
      edge_cap         <= '0;
      rise_en          <= '0;
      fall_en          <= '0;
      stable_q         <= '0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      stable_q <= stable;
      // A new edge in the same cycle as a write-1-to-clear keeps the bit set.
      edge_cap <= (edge_cap & ~edge_clr) | new_edge;
      irq      <= |(edge_cap & mask);
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
      if (avs.avs_write) begin
        case (avs.avs_address)
          ADDR_DATA:   pio_out <= wd;
          ADDR_DIR:    dir     <= wd;
          ADDR_MASK:   mask    <= wd;
          ADDR_RISE:   rise_en <= wd;
          ADDR_FALL:   fall_en <= wd;
          ADDR_OUTSET: pio_out <= pio_out | wd;
          ADDR_OUTCLR: pio_out <= pio_out & ~wd;
          default:     ;
        endcase
      end
    end
  end

endmodule
